// File: rtl/angle_sweep_pkg.sv
// angle_sweep_pkg: shared FSM states and constants for the angle sweep controller
package angle_sweep_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SCALE, OUTPUT} state_t;
  localparam int SCALE_SHIFT = 14;
  localparam int ANGLE_WRAP = 360;
endpackage

// File: rtl/angle_sweep_ctrl_sincos_scaler.sv
// sincos_scaler: scales Q2.14 sin/cos by an unsigned radius with floor-rounded arithmetic shift
module sincos_scaler
  import angle_sweep_pkg::*;
(
  input  logic signed [15:0] sin_in,
  input  logic signed [15:0] cos_in,
  input  logic        [7:0]  radius,
  output logic signed [15:0] x,
  output logic signed [15:0] y
);
  logic signed [24:0] px, py, sx, sy;
  assign px = cos_in * $signed({1'b0, radius});
  assign py = sin_in * $signed({1'b0, radius});
  assign sx = px >>> SCALE_SHIFT;
  assign sy = py >>> SCALE_SHIFT;
  assign x = sx[15:0];
  assign y = sy[15:0];
endmodule

// File: rtl/angle_sweep_ctrl.sv
// angle_sweep_ctrl: sweeps an angle through a sin/cos engine and emits scaled x/y; ANGLE_SWEEP_TIMEOUT_EN adds a WAIT timeout with retry
module angle_sweep_ctrl
  import angle_sweep_pkg::*;
#(
  parameter int STEP_W = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [STEP_W-1:0]   step,
  input  logic [7:0]          radius,
  output logic                cordic_start,
  output logic [15:0]         cordic_angle,
  input  logic                cordic_done,
  input  logic signed [15:0]  cordic_sin,
  input  logic signed [15:0]  cordic_cos,
  output logic signed [15:0]  out_x,
  output logic signed [15:0]  out_y,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                timeout_err
);
  state_t state;
  logic done_q, rise, tmo;
  logic [15:0] angle;
  logic [31:0] sum;
  logic signed [15:0] sx, sy;
  sincos_scaler u_scaler (
    .sin_in(cordic_sin),
    .cos_in(cordic_cos),
    .radius(radius),
    .x(sx),
    .y(sy)
  );
  assign rise = cordic_done && !done_q;
  assign sum = 32'(angle) + (step == '0 ? 32'd1 : 32'(step));
  assign cordic_angle = angle;
  assign cordic_start = state == ISSUE;
  assign out_valid = state == OUTPUT;
  assign busy = state != IDLE;
`ifdef ANGLE_SWEEP_TIMEOUT_EN
  logic [31:0] wcnt;
  logic terr;
  assign tmo = state == WAIT && !rise && wcnt == 32'(TIMEOUT_CYC - 1);
  assign timeout_err = terr;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wcnt <= '0;
      terr <= 1'b0;
    end else begin
      wcnt <= (state == WAIT && !tmo) ? wcnt + 32'd1 : '0;
      if (tmo) terr <= 1'b1;
    end
`else
  assign tmo = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      angle <= '0;
      done_q <= 1'b0;
      out_x <= '0;
      out_y <= '0;
    end else begin
      done_q <= cordic_done;
      case (state)
        IDLE: if (enable) state <= ISSUE;
        ISSUE: state <= WAIT;
        WAIT: state <= rise ? SCALE : tmo ? ISSUE : WAIT;
        SCALE: begin
          out_x <= sx;
          out_y <= sy;
          state <= OUTPUT;
        end
        OUTPUT: if (out_ready) begin
          angle <= sum >= 32'(ANGLE_WRAP) ? 16'(sum - 32'(ANGLE_WRAP)) : 16'(sum);
          state <= enable ? ISSUE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_angle_sweep_ctrl.sv
// tb_angle_sweep_ctrl: directed vector bench with a 33-cycle behavioural sin/cos engine
module tb_angle_sweep_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, out_ready = 1'b0;
  logic [7:0] step = 8'd0, radius = 8'd0;
  logic cordic_start, out_valid, busy, timeout_err;
  logic [15:0] cordic_angle;
  logic signed [15:0] out_x, out_y;
  logic m_done;
  logic signed [15:0] m_sin, m_cos;
  logic [15:0] m_ang;
  int m_cnt;
  logic hold_done = 1'b0, never_done = 1'b0;
  int vecs = 0, errs = 0;
  typedef struct {
    logic rst;
    logic [7:0] step;
    logic [7:0] radius;
    logic hold;
    logic stall;
    int angle;
    int x;
    int y;
  } vec_t;
  vec_t tv[15];
  always #5 clk = ~clk;
  angle_sweep_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable), .step(step), .radius(radius),
    .cordic_start(cordic_start), .cordic_angle(cordic_angle), .cordic_done(m_done),
    .cordic_sin(m_sin), .cordic_cos(m_cos), .out_x(out_x), .out_y(out_y),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .timeout_err(timeout_err)
  );
  function automatic logic signed [15:0] f_cos(input logic [15:0] a);
    case (a)
      16'd0: return 16'sd16384;
      16'd90, 16'd270: return 16'sd0;
      16'd180: return 16'shC006;
      default: return 16'(int'(a) * 40 - 8000);
    endcase
  endfunction
  function automatic logic signed [15:0] f_sin(input logic [15:0] a);
    case (a)
      16'd0, 16'd180: return 16'sd0;
      16'd90: return 16'sd16384;
      16'd270: return -16'sd16384;
      default: return 16'(7000 - int'(a) * 30);
    endcase
  endfunction
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_done <= 1'b0;
      m_cnt <= 0;
      m_ang <= '0;
      m_sin <= '0;
      m_cos <= '0;
    end else if (cordic_start) begin
      m_ang <= cordic_angle;
      m_cnt <= 33;
      if (!hold_done) m_done <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 10 && hold_done) m_done <= 1'b0;
      if (m_cnt == 1 && !never_done) begin
        m_done <= 1'b1;
        m_sin <= f_sin(m_ang);
        m_cos <= f_cos(m_ang);
      end
    end
  function automatic vec_t mk(input logic r, input int st, input int rad, input logic h, input logic s, input int a, input int x, input int y);
    vec_t v;
    v.rst = r; v.step = 8'(st); v.radius = 8'(rad); v.hold = h; v.stall = s;
    v.angle = a; v.x = x; v.y = y;
    return v;
  endfunction
  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic wait_start(output int n);
    n = 0;
    while (!cordic_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("start_timeout", 32'(n < 200), 1);
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", 32'(n < 200), 1);
  endtask
  task automatic run_txn(input vec_t v);
    int n;
    wait_start(n);
    chk("angle", 32'(cordic_angle), v.angle);
    wait_valid(n);
    chk("latency", n, 36);
    chk("out_x", out_x, v.x);
    chk("out_y", out_y, v.y);
    if (v.stall)
      repeat (10) begin
        @(negedge clk);
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_x", out_x, v.x);
        chk("stall_y", out_y, v.y);
        chk("stall_start", 32'(cordic_start), 0);
      end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_valid_drop", 32'(out_valid), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, starts;
    tv[0]  = mk(1'b1, 90, 100, 1'b0, 1'b0, 0, 100, 0);
    tv[1]  = mk(1'b0, 90, 100, 1'b0, 1'b0, 90, 0, 100);
    tv[2]  = mk(1'b0, 90, 100, 1'b0, 1'b1, 180, -100, 0);
    tv[3]  = mk(1'b0, 90, 100, 1'b0, 1'b0, 270, 0, -100);
    tv[4]  = mk(1'b0, 90, 100, 1'b0, 1'b0, 0, 100, 0);
    tv[5]  = mk(1'b1, 0, 100, 1'b0, 1'b0, 0, 100, 0);
    tv[6]  = mk(1'b0, 0, 100, 1'b0, 1'b0, 1, -49, 42);
    tv[7]  = mk(1'b0, 0, 100, 1'b0, 1'b0, 2, -49, 42);
    tv[8]  = mk(1'b1, 250, 200, 1'b0, 1'b0, 0, 200, 0);
    tv[9]  = mk(1'b0, 250, 200, 1'b0, 1'b0, 250, 24, -7);
    tv[10] = mk(1'b0, 250, 200, 1'b0, 1'b0, 140, -30, 34);
    tv[11] = mk(1'b1, 90, 255, 1'b1, 1'b0, 0, 255, 0);
    tv[12] = mk(1'b0, 90, 255, 1'b1, 1'b0, 90, 0, 255);
    tv[13] = mk(1'b0, 90, 255, 1'b1, 1'b0, 180, -255, 0);
    tv[14] = mk(1'b0, 90, 255, 1'b1, 1'b0, 270, 0, -255);
    for (int i = 0; i < 15; i++) begin
      if (tv[i].rst) begin
        reset = 1'b1;
        enable = 1'b0;
        hold_done = tv[i].hold;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_x", out_x, 0);
        chk("rst_y", out_y, 0);
        chk("rst_angle", 32'(cordic_angle), 0);
        chk("rst_start", 32'(cordic_start), 0);
        chk("rst_terr", 32'(timeout_err), 0);
        reset = 1'b0;
        enable = 1'b1;
      end
      step = tv[i].step;
      radius = tv[i].radius;
      run_txn(tv[i]);
    end
    reset = 1'b1;
    hold_done = 1'b0;
    step = 8'd10;
    radius = 8'd50;
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;
    wait_start(n);
    enable = 1'b0;
    chk("stop_angle", 32'(cordic_angle), 0);
    wait_valid(n);
    chk("stop_x", out_x, 50);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stop_busy", 32'(busy), 0);
    starts = 0;
    repeat (40) begin
      @(negedge clk);
      if (cordic_start || busy) starts++;
    end
    chk("stop_idle", starts, 0);
    enable = 1'b1;
    wait_start(n);
    out_ready = 1'b0;
    chk("resume_angle", 32'(cordic_angle), 10);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_angle", 32'(cordic_angle), 0);
    @(negedge clk);
    reset = 1'b0;
    wait_start(n);
    chk("postrst_angle", 32'(cordic_angle), 0);
    wait_valid(n);
    chk("postrst_x", out_x, 50);
    reset = 1'b1;
    #1;
    chk("outrst_valid", 32'(out_valid), 0);
    chk("outrst_x", out_x, 0);
    @(negedge clk);
    reset = 1'b0;
    wait_start(n);
    chk("outrst_angle", 32'(cordic_angle), 0);
`ifdef ANGLE_SWEEP_TIMEOUT_EN
    reset = 1'b1;
    never_done = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_start(n);
    chk("tmo_terr0", 32'(timeout_err), 0);
    @(negedge clk);
    n = 1;
    while (!cordic_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, 65);
    chk("tmo_terr1", 32'(timeout_err), 1);
    chk("tmo_angle", 32'(cordic_angle), 0);
    reset = 1'b1;
    #1;
    chk("tmo_rst", 32'(timeout_err), 0);
    never_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
`endif
    enable = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/angle_sweep_ctrl.md
ANGLE_SWEEP_CTRL -- requirements
Module: angle_sweep_ctrl

Interface
- REQ-001 SHALL have parameter STEP_W, default 8, width of the angle step input.
- REQ-002 SHALL have parameter TIMEOUT_CYC, default 64, cycles to wait for CORDIC done before retry (used only with the timeout feature).
- REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
- REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
- REQ-005 SHALL have port enable, input, 1, level; sweep runs while high.
- REQ-006 SHALL have port step, input, STEP_W, angle increment in degrees; 0 treated as 1.
- REQ-007 SHALL have port radius, input, 8, unsigned output magnitude scale.
- REQ-008 SHALL have port cordic_start, output, 1, one-cycle start pulse to the sin/cos engine.
- REQ-009 SHALL have port cordic_angle, output, 16, angle in degrees, 0..359.
- REQ-010 SHALL have port cordic_done, input, 1, engine done level.
- REQ-011 SHALL have ports cordic_sin and cordic_cos, input, 16 signed each, Q2.14 results (1.0 = 16384).
- REQ-012 SHALL have ports out_x and out_y, output, 16 signed each, scaled coordinates.
- REQ-013 SHALL have ports out_valid (output, 1) and out_ready (input, 1), valid/ready handshake.
- REQ-014 SHALL have ports busy (output, 1, high when not IDLE) and timeout_err (output, 1, sticky).

Function
- REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT, SCALE, OUTPUT.
- REQ-016 IDLE: SHALL go to ISSUE the cycle after enable is sampled high.
- REQ-017 ISSUE: SHALL drive cordic_start=1 for exactly one cycle, with cordic_angle holding the current angle, then go to WAIT.
- REQ-018 WAIT: SHALL register cordic_done each cycle and leave on its rising edge (done=1 and previous=0) only; a done level held over from a previous operation SHALL be ignored.
- REQ-019 SCALE: SHALL compute out_x = (cordic_cos * radius) >>> 14 and out_y = (cordic_sin * radius) >>> 14, arithmetic shift of the 24-bit signed product (floor rounding), truncated to 16 bits; the result is registered; the state lasts 1 cycle.
- REQ-020 OUTPUT: SHALL hold out_valid=1 with stable out_x/out_y until out_valid && out_ready are high in the same cycle.
- REQ-021 On handshake, the angle SHALL update to angle+step, minus 360 if the sum is >=360. The next state SHALL be ISSUE if enable=1, otherwise IDLE.
- REQ-022 Latency from the done rising edge to out_valid SHALL be 2 cycles.
- REQ-023 Deasserting enable mid-sweep SHALL NOT abort the current angle; the sweep stops after its handshake.
- REQ-024 out_ready high outside OUTPUT SHALL have no effect.

Reset
- REQ-025 On reset the FSM SHALL enter IDLE, with angle=0, cordic_angle=0, cordic_start=0, out_x=0, out_y=0, out_valid=0, busy=0, timeout_err=0, and the done history register=0.
- REQ-026 Reset asserted mid-operation SHALL take effect immediately; no pending output SHALL survive.

Configuration
- REQ-027 With ANGLE_SWEEP_TIMEOUT_EN defined, a counter SHALL run in WAIT. If it reaches TIMEOUT_CYC cycles without a done rising edge, timeout_err SHALL set (sticky until reset) and the FSM SHALL return to ISSUE for the same angle.
- REQ-028 Without ANGLE_SWEEP_TIMEOUT_EN, WAIT SHALL wait indefinitely, there SHALL be no counter, and timeout_err SHALL be tied 0.

Structure
- REQ-029 Package angle_sweep_pkg SHALL hold the state enum, SCALE_SHIFT=14, and ANGLE_WRAP=360.
- REQ-030 Sub-module sincos_scaler SHALL perform the two signed x unsigned multiplies and the shift.

Verification (bench uses a behavioural sin/cos model with a 33-cycle done delay)
- REQ-031 Test: reset, radius=100, step=90, enable=1. Required: cordic_angle sequence 0,90,180,270,0. Outputs approx (100,0), (0,100), (-100,0), (0,-100); the angle-180 cos of 0xC006 gives out_x=-100.
- REQ-032 Test: step=0, enable=1. Required: angles 0,1,2; step acts as 1.
- REQ-033 Test: step=250. Required: angles 0,250,140 (wrap).
- REQ-034 Test: out_ready held low 10 cycles in OUTPUT. Required: out_valid stays 1, out_x/out_y stable, no new cordic_start.
- REQ-035 Test: done held high from the previous op when entering WAIT. Required: no capture until done falls and rises again.
- REQ-036 Test (ANGLE_SWEEP_TIMEOUT_EN): the model never asserts done. Required: timeout_err=1 after 64 WAIT cycles, cordic_start re-pulses with the same angle, and reset clears timeout_err.
